// File: rtl/adc_stream_parser.sv
// Receive-side parser for the packetised ADC stream: header checks, timestamp capture, 2-record unpack.
// Define ADC_STREAM_PARSER_SEQ_CHECK_EN to enable sequence-gap counting on err_seq.
module adc_stream_parser #(
    parameter logic [7:0]  EXP_ID      = 8'hDD,
    parameter int unsigned MAX_PKT_LEN = 180,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [63:0]      in_tdata,
    input  logic             in_tfirst,
    input  logic             in_tlast,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [17:0]      smp_data,
    output logic [2:0]       smp_block,
    output logic [6:0]       smp_rate_div,
    output logic [3:0]       smp_ch,
    output logic [63:0]      smp_ts,
    output logic             smp_first,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_id,
    output logic [CNT_W-1:0] err_len,
    output logic [CNT_W-1:0] err_seq
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);

    typedef enum logic [1:0] {S_HDR, S_TS, S_PAY, S_DROP} state_t;

    state_t      state, state_n;
    logic [15:0] word_cnt, word_cnt_n;
    logic [63:0] ts_reg, ts_reg_n;
    logic [31:0] lo_hold, lo_hold_n;
    logic        lo_pend, lo_pend_n;
    logic        first_pend, first_pend_n;
    logic [31:0] rec, rec_n;
    logic [63:0] smp_ts_n;
    logic        smp_first_n, smp_valid_n;
    logic        accept, out_free, hdr_go, pay_acc;
    logic        id_inc, pkt_inc;
    logic [1:0]  len_inc;
    logic [15:0] hdr_len;

`ifdef ADC_STREAM_PARSER_SEQ_CHECK_EN
    logic [31:0] seq_reg, seq_reg_n;
    logic        seq_vld, seq_vld_n;
    logic        seq_inc;
`endif

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign out_free = !smp_valid || smp_ready;
    assign accept   = in_tvalid && in_tready;
    assign hdr_len  = in_tdata[55:40];

    always_comb begin
        if (rst)                 in_tready = 1'b0;
        else if (!ena)           in_tready = 1'b1;
        else if (state == S_PAY) in_tready = out_free && !lo_pend && (word_cnt != '0);
        else                     in_tready = 1'b1;
    end

    always_comb begin
        state_n      = state;
        word_cnt_n   = word_cnt;
        ts_reg_n     = ts_reg;
        first_pend_n = first_pend;
        lo_hold_n    = lo_hold;
        lo_pend_n    = lo_pend;
        rec_n        = rec;
        smp_ts_n     = smp_ts;
        smp_first_n  = smp_first;
        smp_valid_n  = smp_valid;
        hdr_go       = 1'b0;
        pay_acc      = 1'b0;
        id_inc       = 1'b0;
        pkt_inc      = 1'b0;
        len_inc      = '0;
`ifdef ADC_STREAM_PARSER_SEQ_CHECK_EN
        seq_reg_n    = seq_reg;
        seq_vld_n    = seq_vld;
        seq_inc      = 1'b0;
`endif
        if (!ena) begin
            state_n     = S_HDR;
            lo_pend_n   = 1'b0;
            smp_valid_n = 1'b0;
`ifdef ADC_STREAM_PARSER_SEQ_CHECK_EN
            seq_vld_n   = 1'b0;
`endif
        end else begin
            if (accept) begin
                case (state)
                    S_HDR: hdr_go = in_tfirst;
                    S_TS: begin
                        if (in_tfirst) begin
                            len_inc = len_inc + 2'd1;
                            hdr_go  = 1'b1;
                        end else if (in_tlast) begin
                            len_inc = len_inc + 2'd1;
                            state_n = S_HDR;
                        end else begin
                            ts_reg_n = in_tdata;
                            state_n  = S_PAY;
                        end
                    end
                    S_PAY: begin
                        if (in_tfirst) begin
                            len_inc = len_inc + 2'd1;
                            hdr_go  = 1'b1;
                        end else begin
                            pay_acc = 1'b1;
                            // Any tlast ends the packet; stay in PAY (count 0) until the lower record drains.
                            if (in_tlast) begin
                                if (word_cnt == 16'd1) pkt_inc = 1'b1;
                                else                   len_inc = len_inc + 2'd1;
                                word_cnt_n = '0;
                            end else if (word_cnt == 16'd1) begin
                                len_inc    = len_inc + 2'd1;
                                word_cnt_n = '0;
                                state_n    = S_DROP;
                            end else begin
                                word_cnt_n = word_cnt - 16'd1;
                            end
                        end
                    end
                    S_DROP: begin
                        if (in_tfirst)     hdr_go  = 1'b1;
                        else if (in_tlast) state_n = S_HDR;
                    end
                    default: state_n = S_HDR;
                endcase
            end else if (state == S_PAY && word_cnt == '0 && (!lo_pend || out_free)) begin
                state_n = S_HDR;
            end

            if (hdr_go) begin
                if (in_tdata[63:56] != EXP_ID) begin
                    id_inc = 1'b1;
                    if (in_tlast) len_inc = len_inc + 2'd1;
                    state_n = in_tlast ? S_HDR : S_DROP;
                end else if (hdr_len == '0 || hdr_len > MAX_LEN || in_tlast) begin
                    len_inc = len_inc + 2'd1;
                    state_n = in_tlast ? S_HDR : S_DROP;
                end else begin
                    word_cnt_n   = hdr_len;
                    first_pend_n = 1'b1;
                    state_n      = S_TS;
`ifdef ADC_STREAM_PARSER_SEQ_CHECK_EN
                    seq_inc   = seq_vld && (in_tdata[31:0] != seq_reg + 32'd1);
                    seq_reg_n = in_tdata[31:0];
                    seq_vld_n = 1'b1;
`endif
                end
            end

            if (out_free) begin
                if (pay_acc) begin
                    rec_n        = in_tdata[63:32];
                    lo_hold_n    = in_tdata[31:0];
                    lo_pend_n    = 1'b1;
                    smp_first_n  = first_pend;
                    first_pend_n = 1'b0;
                    smp_ts_n     = ts_reg;
                    smp_valid_n  = 1'b1;
                end else if (lo_pend) begin
                    rec_n       = lo_hold;
                    lo_pend_n   = 1'b0;
                    smp_first_n = 1'b0;
                    smp_valid_n = 1'b1;
                end else begin
                    smp_valid_n = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HDR;
            word_cnt   <= '0;
            ts_reg     <= '0;
            lo_hold    <= '0;
            lo_pend    <= 1'b0;
            first_pend <= 1'b0;
            rec        <= '0;
            smp_ts     <= '0;
            smp_first  <= 1'b0;
            smp_valid  <= 1'b0;
            pkt_count  <= '0;
            err_id     <= '0;
            err_len    <= '0;
        end else begin
            state      <= state_n;
            word_cnt   <= word_cnt_n;
            ts_reg     <= ts_reg_n;
            lo_hold    <= lo_hold_n;
            lo_pend    <= lo_pend_n;
            first_pend <= first_pend_n;
            rec        <= rec_n;
            smp_ts     <= smp_ts_n;
            smp_first  <= smp_first_n;
            smp_valid  <= smp_valid_n;
            pkt_count  <= sat_add(pkt_count, {1'b0, pkt_inc});
            err_id     <= sat_add(err_id, {1'b0, id_inc});
            err_len    <= sat_add(err_len, len_inc);
        end
    end

`ifdef ADC_STREAM_PARSER_SEQ_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_reg <= '0;
            seq_vld <= 1'b0;
            err_seq <= '0;
        end else begin
            seq_reg <= seq_reg_n;
            seq_vld <= seq_vld_n;
            err_seq <= sat_add(err_seq, {1'b0, seq_inc});
        end
    end
`else
    assign err_seq = '0;
`endif

    assign smp_data     = rec[31:14];
    assign smp_block    = rec[13:11];
    assign smp_rate_div = rec[10:4];
    assign smp_ch       = rec[3:0];

endmodule

// File: tb/tb_adc_stream_parser.sv
// Directed bench for adc_stream_parser: framing, unpack order, back-pressure, error counters, reset.
module tb_adc_stream_parser;
    logic        clk = 1'b0;
    logic        rst, ena;
    logic [63:0] in_tdata;
    logic        in_tfirst, in_tlast, in_tvalid, in_tready;
    logic [17:0] smp_data;
    logic [2:0]  smp_block;
    logic [6:0]  smp_rate_div;
    logic [3:0]  smp_ch;
    logic [63:0] smp_ts;
    logic        smp_first, smp_valid, smp_ready;
    logic [15:0] pkt_count, err_id, err_len, err_seq;

    int n_checks = 0;
    int n_fail   = 0;
    int rmode    = 0;

    typedef struct packed {
        logic [31:0] raw;
        logic [17:0] d;
        logic [2:0]  b;
        logic [6:0]  r;
        logic [3:0]  c;
        logic [63:0] ts;
        logic        f;
    } rec_t;

    rec_t        q[$];
    rec_t        mon_r;
    logic [96:0] cur, prev;
    logic        stall_prev = 1'b0, rst_prev = 1'b1, ena_prev = 1'b1;

    adc_stream_parser #(.EXP_ID(8'hDD), .MAX_PKT_LEN(180), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_tdata(in_tdata), .in_tfirst(in_tfirst), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .smp_data(smp_data), .smp_block(smp_block), .smp_rate_div(smp_rate_div),
        .smp_ch(smp_ch), .smp_ts(smp_ts), .smp_first(smp_first),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .pkt_count(pkt_count), .err_id(err_id), .err_len(err_len), .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready pattern: 0 = always ready, 1 = toggling, 2 = stalled.
    always @(negedge clk) begin
        case (rmode)
            0:       smp_ready = 1'b1;
            1:       smp_ready = ~smp_ready;
            default: smp_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        #2;
        cur = {smp_data, smp_block, smp_rate_div, smp_ch, smp_ts, smp_first};
        if (!rst && smp_valid && smp_ready) begin
            mon_r.raw = {smp_data, smp_block, smp_rate_div, smp_ch};
            mon_r.d = smp_data;
            mon_r.b = smp_block;
            mon_r.r = smp_rate_div;
            mon_r.c = smp_ch;
            mon_r.ts = smp_ts;
            mon_r.f = smp_first;
            q.push_back(mon_r);
        end
        if (stall_prev && !rst_prev && ena_prev)
            chk("stall_hold", 128'({smp_valid, cur}), 128'({1'b1, prev}));
        stall_prev = smp_valid && !smp_ready;
        rst_prev   = rst;
        ena_prev   = ena;
        prev       = cur;
    end

    function automatic logic [63:0] hdr(input logic [7:0] id, input logic [15:0] n, input logic [31:0] seq);
        return {id, n, 8'h00, seq};
    endfunction

    function automatic rec_t at(input int i);
        if (i < q.size()) return q[i];
        return '0;
    endfunction

    task automatic send(input logic [63:0] d, input logic f, input logic l);
        int   tries = 0;
        logic acc   = 1'b0;
        in_tdata = d; in_tfirst = f; in_tlast = l; in_tvalid = 1'b1;
        while (!acc && tries < 200) begin
            @(negedge clk); #1;
            acc = in_tready;
            @(posedge clk); #1;
            tries++;
        end
        in_tvalid = 1'b0; in_tfirst = 1'b0; in_tlast = 1'b0;
        chk("word_accepted", 128'(acc), 128'(1));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_pkt(input string tag, input logic [31:0] e0, e1, e2, e3, input logic [63:0] ts);
        logic [31:0] e [4];
        rec_t r;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_count"}, 128'(q.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            r = at(i);
            chk($sformatf("%s_rec%0d", tag, i), 128'(r.raw), 128'(e[i]));
            chk($sformatf("%s_ts%0d", tag, i), 128'(r.ts), 128'(ts));
            chk($sformatf("%s_first%0d", tag, i), 128'(r.f), 128'(i == 0));
        end
    endtask

    initial begin
        rec_t r;
        int   bad;
        rst = 1'b1; ena = 1'b1; in_tvalid = 1'b0; in_tfirst = 1'b0; in_tlast = 1'b0;
        in_tdata = '0; smp_ready = 1'b1;
        wait_cyc(3);
        chk("rst_tready", 128'(in_tready), 128'(0));
        chk("rst_valid", 128'(smp_valid), 128'(0));
        chk("rst_pkt", 128'(pkt_count), 128'(0));
        chk("rst_errs", 128'({err_id, err_len, err_seq}), 128'(0));
        rst = 1'b0;
        wait_cyc(1);
        chk("idle_tready", 128'(in_tready), 128'(1));

        // Basic packet, downstream always ready
        q.delete();
        send(hdr(8'hDD, 16'd2, 32'd0), 1'b1, 1'b0);
        send(64'h1234, 1'b0, 1'b0);
        send(64'hAAAA0001_BBBB0002, 1'b0, 1'b0);
        send(64'hCCCC0003_DDDD0004, 1'b0, 1'b1);
        wait_cyc(12);
        chk_pkt("p1", 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004, 64'h1234);
        r = at(1);
        chk("p1_fields", 128'({r.d, r.b, r.r, r.c}), 128'({18'h2EEEC, 3'd0, 7'd0, 4'd2}));
        chk("p1_pkt", 128'(pkt_count), 128'(1));

        // Same packet with toggling ready
        rmode = 1;
        q.delete();
        send(hdr(8'hDD, 16'd2, 32'd1), 1'b1, 1'b0);
        send(64'h1234, 1'b0, 1'b0);
        send(64'hAAAA0001_BBBB0002, 1'b0, 1'b0);
        chk("p2_lo_pend_tready", 128'(in_tready), 128'(0));
        send(64'hCCCC0003_DDDD0004, 1'b0, 1'b1);
        wait_cyc(12);
        rmode = 0;
        wait_cyc(4);
        chk_pkt("p2", 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004, 64'h1234);
        chk("p2_pkt", 128'(pkt_count), 128'(2));

        // Wrong ID packet is dropped, then a good packet
        q.delete();
        send(hdr(8'hDE, 16'd3, 32'd7), 1'b1, 1'b0);
        send(64'h1, 1'b0, 1'b0);
        send(64'h2, 1'b0, 1'b1);
        wait_cyc(4);
        chk("p3_err_id", 128'(err_id), 128'(1));
        chk("p3_no_rec", 128'(q.size()), 128'(0));
        send(hdr(8'hDD, 16'd2, 32'd2), 1'b1, 1'b0);
        send(64'h99, 1'b0, 1'b0);
        send(64'h01020304_05060708, 1'b0, 1'b0);
        send(64'h090A0B0C_0D0E0F10, 1'b0, 1'b1);
        wait_cyc(8);
        chk_pkt("p3", 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 64'h99);
        chk("p3_pkt", 128'(pkt_count), 128'(3));

        // Early tlast: N=3, tlast on 2nd payload word
        q.delete();
        send(hdr(8'hDD, 16'd3, 32'd3), 1'b1, 1'b0);
        send(64'h55, 1'b0, 1'b0);
        send(64'h12345FFF_00000010, 1'b0, 1'b0);
        send(64'h00000020_00000030, 1'b0, 1'b1);
        wait_cyc(8);
        chk_pkt("p4", 32'h12345FFF, 32'h00000010, 32'h00000020, 32'h00000030, 64'h55);
        r = at(0);
        chk("p4_fields", 128'({r.d, r.b, r.r, r.c}), 128'({18'h048D1, 3'd3, 7'h7F, 4'hF}));
        chk("p4_err_len", 128'(err_len), 128'(1));
        chk("p4_pkt", 128'(pkt_count), 128'(3));

        // Length errors: N=181, N=0, tfirst+tlast
        q.delete();
        send(hdr(8'hDD, 16'd181, 32'h100), 1'b1, 1'b0);
        send(64'h66, 1'b0, 1'b0);
        send(64'h77, 1'b0, 1'b0);
        send(64'h88, 1'b0, 1'b1);
        wait_cyc(4);
        chk("n181_err_len", 128'(err_len), 128'(2));
        chk("n181_no_rec", 128'(q.size()), 128'(0));
        send(hdr(8'hDD, 16'd0, 32'h101), 1'b1, 1'b0);
        send(64'h5, 1'b0, 1'b1);
        wait_cyc(2);
        chk("n0_err_len", 128'(err_len), 128'(3));
        send(hdr(8'hDD, 16'd1, 32'h102), 1'b1, 1'b1);
        wait_cyc(2);
        chk("fl_err_len", 128'(err_len), 128'(4));
        chk("fl_tready", 128'(in_tready), 128'(1));

        // Maximum length packet N=180
        q.delete();
        send(hdr(8'hDD, 16'd180, 32'd4), 1'b1, 1'b0);
        send(64'h180, 1'b0, 1'b0);
        for (int i = 0; i < 180; i++)
            send({32'(2 * i), 32'(2 * i + 1)}, 1'b0, i == 179);
        wait_cyc(8);
        chk("n180_count", 128'(q.size()), 128'(360));
        bad = 0;
        for (int i = 0; i < 360; i++) begin
            r = at(i);
            if (r.raw !== 32'(i) || r.f !== (i == 0) || r.ts !== 64'h180) bad++;
        end
        chk("n180_order", 128'(bad), 128'(0));
        chk("n180_pkt", 128'(pkt_count), 128'(4));
        chk("n180_err_len", 128'(err_len), 128'(4));

        // Sequence numbers 5, 6, 8
        for (int s = 5; s <= 8; s++) begin
            if (s != 7) begin
                send(hdr(8'hDD, 16'd1, 32'(s)), 1'b1, 1'b0);
                send(64'h10, 1'b0, 1'b0);
                send(64'h1, 1'b0, 1'b1);
            end
        end
        wait_cyc(4);
        chk("seq_pkt", 128'(pkt_count), 128'(7));
`ifdef ADC_STREAM_PARSER_SEQ_CHECK_EN
        chk("seq_err", 128'(err_seq), 128'(1));
`else
        chk("seq_err", 128'(err_seq), 128'(0));
`endif

        // tfirst in TS: reprocessed as a header
        q.delete();
        send(hdr(8'hDD, 16'd1, 32'd9), 1'b1, 1'b0);
        send(hdr(8'hDD, 16'd1, 32'd10), 1'b1, 1'b0);
        send(64'h77, 1'b0, 1'b0);
        send(64'hFEEDBEEF_CAFEF00D, 1'b0, 1'b1);
        wait_cyc(6);
        chk("tsf_err_len", 128'(err_len), 128'(5));
        chk("tsf_pkt", 128'(pkt_count), 128'(8));
        chk("tsf_count", 128'(q.size()), 128'(2));
        r = at(0);
        chk("tsf_rec0", 128'({r.raw, r.ts, r.f}), 128'({32'hFEEDBEEF, 64'h77, 1'b1}));
        r = at(1);
        chk("tsf_rec1", 128'({r.raw, r.f}), 128'({32'hCAFEF00D, 1'b0}));

        // Disabled parser swallows input without counting
        ena = 1'b0;
        wait_cyc(1);
        chk("dis_tready", 128'(in_tready), 128'(1));
        send(hdr(8'h11, 16'd1, 32'd0), 1'b1, 1'b1);
        wait_cyc(2);
        chk("dis_err_id", 128'(err_id), 128'(1));
        chk("dis_err_len", 128'(err_len), 128'(5));
        ena = 1'b1;
        wait_cyc(1);

        // Reset mid-PAY with a stalled record
        rmode = 2;
        wait_cyc(1);
        send(hdr(8'hDD, 16'd2, 32'd20), 1'b1, 1'b0);
        send(64'h42, 1'b0, 1'b0);
        send(64'h11112222_33334444, 1'b0, 1'b0);
        wait_cyc(2);
        chk("stall_valid", 128'({smp_valid, smp_first}), 128'(2'b11));
        rst = 1'b1;
        wait_cyc(1);
        chk("mid_rst_valid", 128'(smp_valid), 128'(0));
        chk("mid_rst_cnts", 128'({pkt_count, err_id, err_len, err_seq}), 128'(0));
        chk("mid_rst_tready", 128'(in_tready), 128'(0));
        rst = 1'b0;
        rmode = 0;
        wait_cyc(1);
        chk("post_rst_tready", 128'(in_tready), 128'(1));
        q.delete();
        send(hdr(8'hDD, 16'd2, 32'd0), 1'b1, 1'b0);
        send(64'hABC, 1'b0, 1'b0);
        send(64'hAAAA0001_BBBB0002, 1'b0, 1'b0);
        send(64'hCCCC0003_DDDD0004, 1'b0, 1'b1);
        wait_cyc(8);
        chk_pkt("p5", 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004, 64'hABC);
        chk("p5_pkt", 128'(pkt_count), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_stream_parser.md
Name: adc_stream_parser

Overview:
- Receive end of the ADC data stream produced by the subsystem streamer.
- Consumes 64-bit packetised words (tfirst/tlast framing), checks the header, and latches the timestamp.
- Unpacks each payload word into two 32-bit sample records, emitted one per handshake with the packet timestamp attached.
- Sits between the stream FIFO output and downstream consumers (loopback checker, test DMA); keeps error/packet counters for regmap readback.

Parameters:
EXP_ID, 8'hDD, packet ID accepted; other IDs dropped.
MAX_PKT_LEN, 180, max payload words per packet; a larger header count is a length error.
CNT_W, 16, width of status counters.

Ports:
clk  in  1  clock (single domain)
rst  in  1  synchronous active-high reset
ena  in  1  parser enable; low = drain/drop everything
in_tdata  in  64  stream word
in_tfirst  in  1  first word of packet
in_tlast  in  1  last word of packet
in_tvalid  in  1  word valid
in_tready  out  1  word accepted when in_tvalid && in_tready
smp_data  out  18  ADC sample
smp_block  out  3  block field
smp_rate_div  out  7  rate divider field
smp_ch  out  4  channel select field
smp_ts  out  64  timestamp of owning packet
smp_first  out  1  first record of packet
smp_valid  out  1  record valid
smp_ready  in  1  downstream ready
pkt_count  out  CNT_W  good packets completed
err_id  out  CNT_W  ID mismatches
err_len  out  CNT_W  length/framing errors
err_seq  out  CNT_W  sequence gaps (optional feature)

Behaviour:
- Packet format:
  - Word0 (tfirst=1): [63:56] ID, [55:40] payload word count N, [39:32] zero, [31:0] sequence number.
  - Word1: timestamp[63:0].
  - Words 2..N+1: payload; tlast on word N+1.
  - Record layout: [31:14] sample, [13:11] block, [10:4] rate_div, [3:0] channel.
  - Upper record [63:32] is emitted before lower [31:0].
- Reset: state HDR; all outputs, counters, held registers = 0; in_tready = 0 during reset.
- ena=0: state forced to HDR; in_tready = 1 (inputs discarded); smp_valid cleared; counters hold.
- FSM states:
  - HDR: in_tready=1. Accepted word without tfirst is discarded silently. Word with tfirst:
    - ID≠EXP_ID: err_id++, go DROP (or stay HDR if tlast).
    - N=0, N>MAX_PKT_LEN, or tlast set: err_len++, go DROP (or stay HDR if tlast).
    - Otherwise: load word counter=N, store sequence, go TS.
  - TS: in_tready=1. On accept, latch timestamp, go PAY.
    - tfirst set: err_len++ and reprocess that word as a header in the same cycle.
    - tlast set: err_len++, go HDR.
  - PAY: in_tready = (!smp_valid || smp_ready) && !lo_pend.
    - On accept: output register loads upper record (smp_first=1 on the first payload word only), lower record goes to a hold register, lo_pend=1.
    - Next free output slot loads the lower record and clears lo_pend.
    - Counter decrements per word.
    - Last word: tlast=1 → pkt_count++, go HDR after lo_pend clears. tlast=0 → err_len++, go DROP.
    - Early tlast (counter>1): err_len++; both records of that word are still emitted; go HDR.
    - tfirst during PAY: err_len++; word handled as a new header.
  - DROP: in_tready=1; discard until accepted tlast, then HDR. A tfirst word restarts as a header.
- Latency: record valid 1 cycle after payload word acceptance.
- Throughput: one input word per 2 output handshakes.
- Output register holds stable while smp_valid && !smp_ready.
- Counters saturate at all-ones.
- Simultaneous tfirst+tlast is always a length error.

Optional Feature:
- Macro ADC_STREAM_PARSER_SEQ_CHECK_EN.
- Defined: sequence number of each good header is compared to previous+1 (mod 2^32); mismatch → err_seq++. The packet is still processed. The first header after reset or ena rise is never flagged.
- Undefined: no comparison logic; err_seq tied 0.

Test Plan:
- Header ID DD, N=2, seq 0, TS 0x1234, payload 0xAAAA0001_BBBB0002 and 0xCCCC0003_DDDD0004 with tlast, smp_ready=1 → 4 records in order AAAA0001, BBBB0002, CCCC0003, DDDD0004 (fields decoded); smp_ts=0x1234; smp_first only on the first; pkt_count=1.
- Same packet with smp_ready toggling 1/0 → no lost or duplicated record; outputs stable while stalled; in_tready low while lo_pend.
- Header ID 0xDE, 3 words, tlast → err_id=1; no smp_valid; next good packet parsed normally.
- Header N=3, tlast on 2nd payload word → 4 records emitted, err_len=1, pkt_count unchanged. Header N=181 → err_len++, packet dropped.
- With SEQ_CHECK_EN: sequences 5, 6, 8 → err_seq=1, pkt_count=3. Without the macro, err_seq=0.
- Reset asserted mid-PAY with a record stalled → next cycle smp_valid=0, counters 0, state HDR; a fresh packet parses correctly.
